uart_rx_oversample: RTL and testbench
=====================================

// Module: uart_rx_oversample
// PURPOSE
//  UART receiver, 8N1, LSB first. Consumes the 16x-oversample strobe rx_clk_en from the baud-rate generator.
//  Samples asynchronous serial input rxd and recovers each bit by majority vote at the bit centre.
//  Presents each byte on a valid/ack handshake, and flags framing errors and overruns.
//  Sits between the baud-rate generator and the byte consumer (FIFO/CPU register).
// PARAMETERS
//  DATA_BITS   8   data bits per frame (5..8)
//  OVERSAMPLE  16  rx_clk_en strobes per bit period
//  MID         7   first of three majority samples (samples at MID, MID+1, MID+2)
// PORTS
//  clk        in   1          system clock, single domain
//  rst        in   1          asynchronous, active-low reset
//  rx_clk_en  in   1          one-clk strobe at 16x baud rate, from the baud generator
//  rxd        in   1          serial input, asynchronous, idle high
//  rx_ack     in   1          consumer accepts rx_data; sampled only while rx_valid=1
//  rx_data    out  DATA_BITS  last received byte, held until the next frame completes
//  rx_valid   out  1          level; set on frame completion, cleared by rx_ack
//  frame_err  out  1          one-clk pulse, coincident with frame completion when stop bit=0
//  overrun    out  1          one-clk pulse when a frame completes while rx_valid=1
//  busy       out  1          1 in any state except IDLE
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE; rx_data=0; rx_valid, frame_err, overrun, busy=0; counters=0; sync FFs=1.
//  rxd passes through a 2-FF synchroniser (reset to 1). All decisions use the synchronised value rxs.
//  All state and counter advances occur only on clk edges where rx_clk_en=1. Output handshake runs every clk.
//  tick: 4-bit counter, 0..OVERSAMPLE-1, wraps to 0. bitn: 3-bit count of data bits.
//  FSM:
//   IDLE:  rxs=0 -> START, tick=0.
//   START: at tick=MID+2, vote3=majority of the samples at MID, MID+1, MID+2.
//          vote3=1 (false start) -> IDLE. Otherwise continue. tick=15 -> DATA, bitn=0.
//   DATA:  at tick=MID+2, shift vote3 into the shift register MSB (LSB-first assembly).
//          tick=15: if bitn=DATA_BITS-1 -> STOP, else bitn+1.
//   STOP:  at tick=MID+2 the frame completes. Go to IDLE if vote3=1, else to BREAK.
//          Leaving at mid-stop keeps the rx ready for a back-to-back start edge.
//   BREAK: stay until rxs=1 (on a strobe), then -> IDLE. No frame is reported while in BREAK.
//  Frame completion, registered, on the clk after the STOP decision strobe:
//   rx_data <= shift register; rx_valid <= 1.
//   frame_err = ~vote3 for 1 clk. The data is still delivered.
//   overrun = 1 for 1 clk if rx_valid was already 1 and rx_ack was not asserted in that same clk. New data overwrites.
//  Handshake:
//   rx_ack=1 while rx_valid=1 clears rx_valid on the next clk.
//   If a completion and rx_ack occur in the same clk, completion wins: rx_valid stays 1 and there is no overrun.
//   rx_ack while rx_valid=0 is ignored.
//  Latency: rxd start edge to rx_valid = 2 sync clks + (1+DATA_BITS)*16 + MID+3 strobes + 1 clk.
//  Majority vote: 2 of 3 ones -> 1, so a single-sample glitch is rejected.
//  If rst is asserted mid-frame, the partial frame is discarded with no valid, error or overrun pulse.
//  After release the rx waits in IDLE for a fresh falling edge.
//  rx_clk_en held 0: the FSM freezes in place. The handshake still operates.
// STRUCTURE
//  Shared package uart_pkg:
//   state encoding (IDLE, START, DATA, STOP, BREAK, 3 bits)
//   OVERSAMPLE and DATA_BITS defaults
//   function maj3(a,b,c)
//  One natural sub-module: uart_sync2 (2-FF synchroniser, async reset to 1), reusable by other rx paths.
//  Remainder: FSM, tick/bit counters, 3-sample vote register, shift register, output/handshake regs.
// TESTING (bench drives rx_clk_en every 4 clks; 1 bit = 16 strobes)
//  1 Frame 0xA5, stop=1, ack 3 clks after valid -> rx_data=0xA5, rx_valid 1 then 0, frame_err=0, overrun=0.
//  2 rxd low for 3 strobes then high -> START aborts to IDLE; no rx_valid; busy returns to 0.
//  3 Frame 0x3C with data bit 2 glitched low for one sample at tick 8 -> rx_data=0x3C (majority corrects).
//  4 Frame 0x55 with stop=0, line held low 2 bit times -> rx_data=0x55, frame_err pulse, FSM stays in BREAK until rxd=1.
//  5 Back-to-back 0x00 then 0xFF, no ack -> first rx_valid; second completion gives overrun pulse and rx_data=0xFF.
//  6 rst pulsed low during data bit 4, then frame 0x81 -> no output for the partial frame; next rx_data=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, default framing
// parameters and the 2-of-3 majority helper used for bit recovery.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;
    localparam int MID_DEF        = 7;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high serial line.
// Resets to 1 so a line held in reset never looks like a start bit.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1-style UART receiver driven by a 16x oversample strobe. Each bit is
// recovered by a 2-of-3 vote at the bit centre and delivered on valid/ack.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int MID        = MID_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_clk_en,
    input  logic                 rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int                TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(MID);
    localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(MID + 1);
    localparam logic [TICK_W-1:0] TICK_VOTE = TICK_W'(MID + 2);
    localparam logic [2:0]        BITN_LAST = 3'(DATA_BITS - 1);

    logic rxs;

    state_t               state_q,     state_d;
    logic [TICK_W-1:0]    tick_q,      tick_d;
    logic [2:0]           bitn_q,      bitn_d;
    logic [1:0]           samp_q,      samp_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 done_q,      done_d;
    logic                 stop_ok_q,   stop_ok_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;
    logic                 vote3;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    // Samples at MID and MID+1 are held; the third is the live sample at MID+2.
    assign vote3 = maj3(samp_q[1], samp_q[0], rxs);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bitn_d    = bitn_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        stop_ok_d = stop_ok_q;

        if (rx_clk_en) begin
            if (state_q != ST_IDLE && state_q != ST_BREAK) begin
                tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
                if (tick_q == TICK_S0 || tick_q == TICK_S1) begin
                    samp_d = {samp_q[0], rxs};
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_VOTE && vote3) begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end else if (tick_q == TICK_LAST) begin
                        state_d = ST_DATA;
                        bitn_d  = '0;
                    end
                end
                ST_DATA: begin
                    if (tick_q == TICK_VOTE) begin
                        shift_d = {vote3, shift_q[DATA_BITS-1:1]};
                    end
                    if (tick_q == TICK_LAST) begin
                        if (bitn_q == BITN_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bitn_d = bitn_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (tick_q == TICK_VOTE) begin
                        done_d    = 1'b1;
                        stop_ok_d = vote3;
                        tick_d    = '0;
                        state_d   = vote3 ? ST_IDLE : ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // A completion in the same clk as rx_ack keeps rx_valid set and is no overrun.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        if (done_q) begin
            rx_data_d   = shift_q;
            rx_valid_d  = 1'b1;
            frame_err_d = ~stop_ok_q;
            overrun_d   = rx_valid_q & ~rx_ack;
        end else if (rx_valid_q && rx_ack) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bitn_q      <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            stop_ok_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bitn_q      <= bitn_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            stop_ok_q   <= stop_ok_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: directed frames with a strobe every
// 4 clks (64 clks per bit); a monitor checks each delivered byte against a queue.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       rx_clk_en = 1'b0;
    logic       rxd       = 1'b1;
    logic       rx_ack    = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int phase   = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    uart_rx_oversample #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .MID        (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_clk_en (rx_clk_en),
        .rxd       (rxd),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    // One clk of stimulus: line value plus the 1-in-4 oversample strobe.
    task automatic step(input logic v);
        @(negedge clk);
        rxd       = v;
        rx_clk_en = (phase == 0);
        phase     = (phase + 1) % 4;
    endtask

    task automatic hold(input logic v, input int n);
        repeat (n) step(v);
    endtask

    task automatic align();
        while (phase != 0) step(1'b1);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic fe, input logic ov);
        exp_t e;
        e.data = d;
        e.ferr = fe;
        e.ovr  = ov;
        exp_q.push_back(e);
    endtask

    // Start bit, 8 LSB-first data bits, then the stop level for stop_steps clks.
    // glitch_bit >= 0 pulls that data bit low for the single clk seen at tick 8.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_steps,
                              input int glitch_bit);
        align();
        hold(1'b0, 64);
        for (int i = 0; i < 8; i++) begin
            for (int s = 0; s < 64; s++) begin
                step((i == glitch_bit && s == 38) ? 1'b0 : d[i]);
            end
        end
        hold(stop_v, stop_steps);
    endtask

    task automatic wait_valid(input string name, input int bound);
        int n;
        n = 0;
        while (rx_valid !== 1'b1 && n < bound) begin
            step(1'b1);
            n++;
        end
        check(name, 32'(rx_valid), 32'd1);
    endtask

    task automatic ack_and_check(input string name);
        rx_ack = 1'b1;
        step(rxd);
        rx_ack = 1'b0;
        check(name, 32'(rx_valid), 32'd0);
    endtask

    // Monitor: a completion is a valid rise, an overrun, or valid surviving an ack.
    initial begin
        logic prev_valid;
        logic completion;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            completion = rx_valid && (!prev_valid || rx_ack || overrun);
            if (completion) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame: got data=%02h ferr=%b ovr=%b, required no frame",
                             rx_data, frame_err, overrun);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e.data || frame_err !== e.ferr || overrun !== e.ovr) begin
                        n_fail++;
                        $display("FAIL frame: got data=%02h ferr=%b ovr=%b, required data=%02h ferr=%b ovr=%b",
                                 rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
                    end else begin
                        $display("[TB] ok   frame data=%02h ferr=%b ovr=%b", rx_data, frame_err, overrun);
                    end
                end
            end else if (frame_err || overrun) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_pulse: got ferr=%b ovr=%b valid=%b, required no pulse",
                         frame_err, overrun, rx_valid);
            end
            prev_valid = rx_valid;
        end
    end

    initial begin
        // Reset state
        hold(1'b1, 3);
        check("rst_rx_data",   32'(rx_data),   32'h00);
        check("rst_rx_valid",  32'(rx_valid),  32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst = 1'b1;
        hold(1'b1, 40);

        // 1: 0xA5, good stop, ack 3 clks after valid
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 0, -1);
        wait_valid("t1_valid", 100);
        hold(1'b1, 3);
        ack_and_check("t1_ack_clears");
        hold(1'b1, 64);

        // 2: short low pulse is a false start
        align();
        hold(1'b0, 12);
        hold(1'b1, 8);
        check("t2_busy_in_start", 32'(busy), 32'd1);
        hold(1'b1, 40);
        check("t2_busy_after_abort", 32'(busy), 32'd0);
        check("t2_no_valid", 32'(rx_valid), 32'd0);
        hold(1'b1, 64);

        // 3: 0x3C with one glitched sample in data bit 2
        push_exp(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 64, 2);
        check("t3_valid", 32'(rx_valid), 32'd1);
        ack_and_check("t3_ack_clears");
        hold(1'b1, 64);

        // 4: 0x55 with stop=0 and line low two bit times -> BREAK
        push_exp(8'h55, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 128, -1);
        check("t4_busy_in_break", 32'(busy), 32'd1);
        check("t4_valid", 32'(rx_valid), 32'd1);
        hold(1'b1, 16);
        check("t4_busy_after_break", 32'(busy), 32'd0);
        ack_and_check("t4_ack_clears");
        hold(1'b1, 64);

        // 5: back-to-back 0x00 then 0xFF, no ack in between
        push_exp(8'h00, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 64, -1);
        push_exp(8'hFF, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 64, -1);
        check("t5_data_overwritten", 32'(rx_data), 32'hFF);
        ack_and_check("t5_ack_clears");
        hold(1'b1, 64);

        // 6: reset during data bit 4, then a clean 0x81
        align();
        hold(1'b0, 64);
        for (int i = 0; i < 4; i++) hold(((8'h81 >> i) & 8'h01) != 0, 64);
        hold(1'b0, 32);
        rst = 1'b0;
        hold(1'b1, 2);
        check("t6_busy_in_rst", 32'(busy), 32'd0);
        rst = 1'b1;
        hold(1'b1, 64);
        check("t6_busy_after_rst", 32'(busy), 32'd0);
        check("t6_no_valid", 32'(rx_valid), 32'd0);
        push_exp(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, 64, -1);
        check("t6_valid", 32'(rx_valid), 32'd1);
        ack_and_check("t6_ack_clears");
        hold(1'b1, 32);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
